// File: rtl/ysyx_25070198_dmem_responder.sv
// Data-memory responder for the LSU request port: word array, byte-masked writes, fixed or LFSR-driven latency.
// Define DMEM_RAND_LAT_EN to draw a per-request latency of 1..8 from an 8-bit LFSR instead of LATENCY.
module ysyx_25070198_dmem_responder #(
  parameter int          LATENCY   = 2,
  parameter int          DEPTH     = 1024,
  parameter logic [29:0] BASE_WORD = 30'h20000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [29:0] mem_addr,
  input  logic [3:0]  mem_mask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_data_valid,
  output logic        lsu_busy,
  output logic        mem_err
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx, load;
  logic        accept, commit, resp_go;
  logic [29:0] addr_q, op_addr, op_idx;
  logic [3:0]  mask_q, op_mask;
  logic [31:0] wdata_q, op_wdata, wr_word;
  logic        wr_q, in_range;
  logic [IW-1:0] arr_idx;
  logic [31:0] mem [DEPTH];

`ifdef DMEM_RAND_LAT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign load = lfsr[2:0];
`else
  assign load = 3'(LATENCY - 1);
`endif

  // A zero load value finishes the transaction on the accept edge itself,
  // so the operand mux must select the live request inputs in that case.
  always_comb begin
    accept   = (state == IDLE) && (mem_ren || mem_wen);
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    resp_go  = 1'b0;
    op_addr  = addr_q;
    op_mask  = mask_q;
    op_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_addr  = mem_addr;
          op_mask  = mem_mask;
          op_wdata = mem_wdata;
          if (load == 3'd0) begin
            if (mem_wen) begin
              commit = 1'b1;
            end else begin
              resp_go  = 1'b1;
              state_nx = RESP;
            end
          end else begin
            state_nx = WAIT;
            cnt_nx   = load;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          if (wr_q) begin
            commit   = 1'b1;
            state_nx = IDLE;
          end else begin
            resp_go  = 1'b1;
            state_nx = RESP;
          end
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_idx   = op_addr - BASE_WORD;
    in_range = (op_idx < DEPTH_W);
    arr_idx  = op_idx[IW-1:0];
    wr_word  = mem[arr_idx];
    for (int b = 0; b < 4; b++) begin
      if (op_mask[b]) wr_word[8*b +: 8] = op_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      mem_rdata <= 32'd0;
      mem_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mem_err <= (resp_go || commit) && !in_range;
      if (resp_go) mem_rdata <= in_range ? mem[arr_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      mask_q  <= mem_mask;
      wdata_q <= mem_wdata;
      wr_q    <= mem_wen;
    end
  end

  // Array contents survive reset; an aborted write never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && in_range) mem[arr_idx] <= wr_word;
  end

  assign mem_data_valid = (state == RESP);
  assign lsu_busy       = (state == WAIT);

endmodule

// File: tb/tb_ysyx_25070198_dmem_responder.sv
// Scoreboard bench for the data-memory responder: two instances (latency 2 and 1) driven by random requests.
module tb_ysyx_25070198_dmem_responder;

  localparam logic [29:0] BASE = 30'h20000000;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          acc;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst    [2];
  logic        ren    [2];
  logic        wen    [2];
  logic [29:0] addr   [2];
  logic [3:0]  mask   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic        valid  [2];
  logic        busy   [2];
  logic        err    [2];

  exp_t        sq [2][$];
  logic [31:0] mdl [logic [30:0]];
  logic [31:0] hold_v [2];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
`ifdef DMEM_RAND_LAT_EN
  logic [7:0]  lfsr_m [2];
`endif

  ysyx_25070198_dmem_responder #(.LATENCY(2), .DEPTH(1024), .BASE_WORD(30'h20000000)) dut0 (
    .clk(clk), .rst(rst[0]), .mem_ren(ren[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
    .mem_mask(mask[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_data_valid(valid[0]), .lsu_busy(busy[0]), .mem_err(err[0]));

  ysyx_25070198_dmem_responder #(.LATENCY(1), .DEPTH(1024), .BASE_WORD(30'h20000000)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_ren(ren[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
    .mem_mask(mask[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_data_valid(valid[1]), .lsu_busy(busy[1]), .mem_err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  function automatic int next_lat(input int i);
    int l;
`ifdef DMEM_RAND_LAT_EN
    l = 1 + int'(lfsr_m[i][2:0]);
    lfsr_m[i] = {lfsr_m[i][6:0], lfsr_m[i][7] ^ lfsr_m[i][5] ^ lfsr_m[i][4] ^ lfsr_m[i][3]};
`else
    l = (i == 0) ? 2 : 1;
`endif
    return l;
  endfunction

  // Expected response is computed from the word model at issue time; requests are serialized.
  task automatic issue_l(input int i, input int lat, input bit rd, input bit wr, input logic [29:0] a,
                         input logic [3:0] m, input logic [31:0] d, input int hold);
    exp_t        e;
    logic [29:0] idx;
    logic [30:0] key;
    logic [31:0] w;
    int          h;
    idx   = a - BASE;
    key   = {i[0], a};
    e.rd  = !wr;
    e.err = (idx >= 30'd1024);
    e.acc = cyc + 1;
    e.due = cyc + lat;
    e.data = 32'd0;
    if (e.rd && !e.err && mdl.exists(key)) e.data = mdl[key];
    if (wr && !e.err) begin
      w = mdl.exists(key) ? mdl[key] : 32'd0;
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[key] = w;
    end
    sq[i].push_back(e);
    h = wr ? lat - 1 : lat;
    if (hold < h) h = hold;
    ren[i] = rd; wen[i] = wr; addr[i] = a; mask[i] = m; wdata[i] = d;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k > h) begin
        ren[i] = 1'b0;
        wen[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input bit rd, input bit wr, input logic [29:0] a,
                       input logic [3:0] m, input logic [31:0] d, input int hold);
    issue_l(i, next_lat(i), rd, wr, a, m, d, hold);
  endtask

  // Write that is cut off by reset while still counting down; the model never sees it.
  task automatic abort_write(input int i, input logic [29:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    lat = next_lat(i);
    if (lat < 2) begin
      issue_l(i, lat, 1'b0, 1'b1, a, 4'hF, d, 0);
    end else begin
      e.rd = 1'b0; e.err = 1'b0; e.data = 32'd0; e.acc = cyc + 1; e.due = cyc + lat;
      sq[i].push_back(e);
      wen[i] = 1'b1; addr[i] = a; mask[i] = 4'hF; wdata[i] = d;
      @(negedge clk);
      wen[i] = 1'b0;
      #2;
      rst[i] = 1'b0;
      sq[i].delete();
      hold_v[i] = 32'd0;
`ifdef DMEM_RAND_LAT_EN
      lfsr_m[i] = 8'hA5;
`endif
      #1;
      chk("abort_rdata", rdata[i], 32'd0);
      chk("abort_valid", valid[i], 32'd0);
      chk("abort_busy",  busy[i],  32'd0);
      chk("abort_err",   err[i],   32'd0);
      @(negedge clk);
      rst[i] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic ev, ex_v, ex_e, ex_b;
      ev   = (sq[i].size() > 0) && (sq[i][0].due == cyc);
      ex_b = (sq[i].size() > 0) && (sq[i][0].acc <= cyc) && (cyc < sq[i][0].due);
      ex_v = ev && sq[i][0].rd;
      ex_e = ev && sq[i][0].err;
      if (ex_v) hold_v[i] = sq[i][0].data;
      chk($sformatf("valid%0d", i), valid[i], ex_v);
      chk($sformatf("busy%0d", i),  busy[i],  ex_b);
      chk($sformatf("err%0d", i),   err[i],   ex_e);
      chk($sformatf("rdata%0d", i), rdata[i], hold_v[i]);
      if (ev) void'(sq[i].pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [29:0] a;
    int          r, op;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; ren[i] = 1'b0; wen[i] = 1'b0;
      addr[i] = 30'd0; mask[i] = 4'd0; wdata[i] = 32'd0; hold_v[i] = 32'd0;
`ifdef DMEM_RAND_LAT_EN
      lfsr_m[i] = 8'hA5;
`endif
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 2; i++)
      for (int k = 0; k <= 16; k++)
        issue(i, 1'b0, 1'b1, (k == 16) ? BASE + 30'd1023 : BASE + 30'(k), 4'hF, $urandom, 0);

    issue(0, 1'b0, 1'b1, 30'h20000004, 4'b1111, 32'hDEADBEEF, 0);
    issue(0, 1'b1, 1'b0, 30'h20000004, 4'b0000, 32'h0, 0);
    issue(0, 1'b0, 1'b1, 30'h20000004, 4'b0100, 32'h00AB0000, 1);
    issue(0, 1'b1, 1'b0, 30'h20000004, 4'b0000, 32'h0, 2);
    issue(0, 1'b0, 1'b1, 30'h20000004, 4'b0000, 32'hFFFFFFFF, 0);
    issue(0, 1'b1, 1'b0, 30'h20000400, 4'b0000, 32'h0, 0);
    issue(0, 1'b0, 1'b1, 30'h20000400, 4'b1111, 32'h12345678, 0);
    issue(0, 1'b1, 1'b0, 30'h20000000, 4'b0000, 32'h0, 0);
    issue(0, 1'b1, 1'b1, 30'h20000005, 4'b1111, 32'hCAFEF00D, 0);
    issue(0, 1'b1, 1'b0, 30'h20000005, 4'b0000, 32'h0, 0);
    abort_write(0, 30'h20000004, 32'h11111111);
    issue(0, 1'b1, 1'b0, 30'h20000004, 4'b0000, 32'h0, 0);

    issue(1, 1'b1, 1'b0, 30'h20000003, 4'b0000, 32'h0, 1);
    issue(1, 1'b0, 1'b1, 30'h200003FF, 4'b0011, 32'h0000A5A5, 0);
    issue(1, 1'b1, 1'b0, 30'h200003FF, 4'b0000, 32'h0, 1);
    issue(1, 1'b1, 1'b0, 30'h20000400, 4'b0000, 32'h0, 0);
    issue(1, 1'b1, 1'b1, 30'h20000002, 4'b1001, 32'h77000088, 0);
    issue(1, 1'b1, 1'b0, 30'h20000002, 4'b0000, 32'h0, 0);

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 60; n++) begin
        r = int'($urandom_range(0, 19));
        if (r < 16)       a = BASE + 30'(r);
        else if (r == 16) a = BASE + 30'd1023;
        else if (r == 17) a = BASE + 30'd1024;
        else if (r == 18) a = BASE - 30'd1;
        else              a = 30'd0;
        op = int'($urandom_range(0, 2));
        issue(i, op != 1, op != 0, a, 4'($urandom), $urandom, int'($urandom_range(0, 3)));
      end
    end

    repeat (4) @(negedge clk);
    chk("drain", sq[0].size() + sq[1].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25070198_dmem_responder.md
Name: ysyx_25070198_dmem_responder

Overview:
- Data-memory responder: the memory side of the LSU request interface that the EXU drives (mem_ren/mem_wen/mem_addr/mem_mask/mem_wdata).
- Returns mem_rdata with a one-cycle mem_data_valid, and drives lsu_busy to the IFU and EXU.
- Holds an internal word-organised array with byte-masked writes and a parameterised response latency.
- Replaces the DPI memory model for simulation of the data path.

Parameters:
- LATENCY, 2, cycles from request-accept edge to mem_data_valid for reads and to commit for writes; legal range 1..8.
- DEPTH, 1024, number of 32-bit words in the array.
- BASE_WORD, 30'h20000000, word address mapped to index 0 (byte 0x80000000).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; asynchronous, active-low
- mem_ren  input  1  read request
- mem_wen  input  1  write request
- mem_addr  input  30  word address
- mem_mask  input  4  byte enables for writes; bit i enables byte i
- mem_wdata  input  32  write data, already lane-aligned by requester
- mem_rdata  output  32  read data, full word
- mem_data_valid  output  1  read response pulse
- lsu_busy  output  1  request in flight, new requests ignored
- mem_err  output  1  out-of-range access flag, pulses with the response

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE; the counter clears.
  - mem_rdata=0, mem_data_valid=0, lsu_busy=0, mem_err=0.
  - The array is not cleared.
  - Reset asserted mid-operation aborts the transaction; a pending write is dropped.
- States:
  - IDLE: accepts requests.
  - WAIT: latency countdown.
  - RESP: read response, exactly 1 cycle.
- Accept: only in IDLE, on a rising edge with mem_ren|mem_wen high.
  - Latch addr, mask, wdata and op.
  - Requests seen in WAIT or RESP are ignored, not queued.
- Simultaneous mem_ren and mem_wen: the write wins; the read is discarded.
- Index = mem_addr - BASE_WORD (30-bit unsigned wrap). In range iff index < DEPTH.
- Counter load at accept: LATENCY-1 (3-bit).
  - If the load value is 0, skip WAIT: a read goes to RESP, a write commits and stays in IDLE.
  - In WAIT, decrement each cycle. At 0, a read goes to RESP; a write commits and goes to IDLE.
- Read timing (accept edge ends cycle 0):
  - mem_data_valid=1 in cycle LATENCY only.
  - mem_rdata is registered on entry to RESP, holds until the next read response, and is unchanged by writes.
  - Out of range: mem_rdata=0 and mem_err=1 in the RESP cycle.
- Write:
  - Bytes with mask=1 update at the commit edge; mask=0 changes nothing but still consumes LATENCY cycles.
  - A read accepted after the commit sees the new data.
  - Out of range: no array update; mem_err pulses 1 in the cycle after commit.
  - No mem_data_valid for writes.
- lsu_busy = (state==WAIT). Low in RESP, so the IFU hold releases on the same cycle mem_data_valid is seen.
- Requester contract: drop mem_ren by the cycle after RESP. A mem_ren still high in IDLE is a new request.
- The array is indexed with ceil(log2(DEPTH)) bits after the range check.

Optional Feature:
- Macro DMEM_RAND_LAT_EN.
- Defined:
  - Per-request latency = 1 + lfsr[2:0], range 1..8; LATENCY is ignored.
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5 at reset, and advances once per accepted request.
  - All handshake rules above are unchanged.
- Undefined: fixed LATENCY; no LFSR logic.

Test Plan:
- Reset release, no requests, 10 cycles -> all outputs 0, lsu_busy 0.
- LATENCY=2: write addr 30'h20000004, mask 4'b1111, data 32'hDEADBEEF; then read the same addr -> lsu_busy 1 for one cycle after each accept; mem_data_valid in read cycle 2; mem_rdata 32'hDEADBEEF; mem_err 0.
- Byte write mask 4'b0100, wdata 32'h00AB0000 to the same word, then read -> 32'hDEABBEEF.
- LATENCY=1 read -> mem_data_valid in the cycle after accept, lsu_busy never 1; mem_ren held high during RESP -> no second accept until IDLE.
- Read addr 30'h20000400 (index 1024) -> mem_rdata 0, mem_err 1 with mem_data_valid; out-of-range write -> array unchanged.
- Simultaneous mem_ren+mem_wen -> write committed, no mem_data_valid. rst low while in WAIT during a write -> outputs 0 immediately, word unchanged on later read.
